// File: rtl/serial_tx_arbiter_if.sv
// rtl/serial_tx_arbiter_if.sv - requester handshakes and serial output bundle for serial_tx_arbiter
interface serial_tx_arbiter_if #(
  parameter int N = 4
);
  logic         req0_valid;
  logic [N-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [N-1:0] req1_data;
  logic         req1_ready;
  logic         s_out;
  logic         s_en;
  logic         s_last;
  logic         grant_id;
  logic         busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, s_out, s_en, s_last, grant_id, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, s_out, s_en, s_last, grant_id, busy
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - two-requester round-robin arbiter feeding one LSB-first serial line
module serial_tx_arbiter #(
  parameter int N   = 4,
  parameter int GAP = 1,
  parameter int CW  = $clog2(N)
) (
  input logic              clk,
  input logic              rst_n,
  serial_tx_arbiter_if.slave bus
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic          prio;
  logic          grant_q;
  logic          pick0, pick1, last_bit, gap_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // prio holds the last winner; the other requester wins a tie.
  always_comb begin
    pick0          = bus.req0_valid && (!bus.req1_valid || prio);
    pick1          = bus.req1_valid && (!bus.req0_valid || !prio);
    last_bit       = (cnt == CW'(N - 1));
    gap_done       = (int'(gcnt) == GAP - 1);
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.s_out      = 1'b0;
    bus.s_en       = 1'b0;
    bus.s_last     = 1'b0;
    bus.grant_id   = grant_q;
    bus.busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        bus.req0_ready = pick0;
        bus.req1_ready = pick1;
        if (pick0 || pick1) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        bus.s_out  = shreg[0];
        bus.s_en   = 1'b1;
        bus.s_last = last_bit;
        if (last_bit) state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      prio    <= 1'b1;
      grant_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick0 || pick1) begin
            shreg   <= pick1 ? bus.req1_data : bus.req0_data;
            grant_q <= pick1;
            prio    <= pick1;
            cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          shreg <= {1'b0, shreg[N-1:1]};
          cnt   <= cnt + 1'b1;
          if (last_bit) gcnt <= '0;
        end
        ST_GAP: begin
          gcnt <= gcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - directed self-checking bench for serial_tx_arbiter
module tb_serial_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_tx_arbiter_if #(.N(N)) bus_a ();
  serial_tx_arbiter_if #(.N(N)) bus_b ();

  serial_tx_arbiter #(.N(N), .GAP(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  serial_tx_arbiter #(.N(N), .GAP(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus_a.req0_valid = 1'b0; bus_a.req0_data = '0;
    bus_a.req1_valid = 1'b0; bus_a.req1_data = '0;
    bus_b.req0_valid = 1'b0; bus_b.req0_data = '0;
    bus_b.req1_valid = 1'b0; bus_b.req1_data = '0;
  endtask

  task automatic wait_idle_a(input string name);
    int n;
    n = 0;
    while (bus_a.busy !== 1'b0 && n < 20) begin
      step;
      n++;
    end
    #1;
    checks++;
    if (bus_a.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout busy=%b exp=0", name, bus_a.busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checks++; if (bus_a.s_en !== 1'b0) begin failures++; $display("FAIL reset_s_en got=%b exp=0", bus_a.s_en); end
    checks++; if (bus_a.s_out !== 1'b0) begin failures++; $display("FAIL reset_s_out got=%b exp=0", bus_a.s_out); end
    checks++; if (bus_a.s_last !== 1'b0) begin failures++; $display("FAIL reset_s_last got=%b exp=0", bus_a.s_last); end
    checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_a.busy); end
    checks++; if (bus_a.grant_id !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0", bus_a.grant_id); end
    checks++; if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {bus_a.req0_ready, bus_a.req1_ready}); end
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_single;
    logic [3:0] exp_w;
    exp_w = 4'b1011;
    bus_a.req0_valid = 1'b1;
    bus_a.req0_data  = exp_w;
    #1;
    checks++; if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", {bus_a.req0_ready, bus_a.req1_ready}); end
    step;
    bus_a.req0_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_a.s_en !== 1'b1) begin failures++; $display("FAIL single_s_en bit%0d got=%b exp=1", i, bus_a.s_en); end
      checks++; if (bus_a.s_out !== exp_w[i]) begin failures++; $display("FAIL single_s_out bit%0d got=%b exp=%b", i, bus_a.s_out, exp_w[i]); end
      checks++; if (bus_a.s_last !== (i == 3)) begin failures++; $display("FAIL single_s_last bit%0d got=%b exp=%b", i, bus_a.s_last, (i == 3)); end
      checks++; if (bus_a.grant_id !== 1'b0) begin failures++; $display("FAIL single_grant bit%0d got=%b exp=0", i, bus_a.grant_id); end
      step;
    end
    checks++; if ({bus_a.s_en, bus_a.s_out, bus_a.busy} !== 3'b001) begin failures++; $display("FAIL single_gap en_out_busy got=%b exp=001", {bus_a.s_en, bus_a.s_out, bus_a.busy}); end
    step;
    checks++; if ({bus_a.s_en, bus_a.busy} !== 2'b00) begin failures++; $display("FAIL single_after en_busy got=%b exp=00", {bus_a.s_en, bus_a.busy}); end
  endtask

  task automatic test_contention;
    int st[4];
    logic g[4];
    logic [3:0] wd[4];
    logic [3:0] w;
    logic [3:0] exp_w;
    int nfr, bi;
    logic pe;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    nfr = 0; bi = 0; pe = 1'b0; w = '0;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 4'hA;
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 4'h5;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus_a.s_en === 1'b1) begin
        if (!pe) begin
          bi = 0;
          if (nfr < 4) begin st[nfr] = c; g[nfr] = bus_a.grant_id; end
        end
        if (bi < 4) w[bi] = bus_a.s_out;
        bi++;
        if (bus_a.s_last === 1'b1) begin
          if (nfr < 4) wd[nfr] = w;
          nfr++;
        end
      end
      pe = bus_a.s_en;
      step;
    end
    checks++;
    if (nfr < 4) begin
      failures++;
      $display("FAIL contention_frames got=%0d exp>=4", nfr);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_w = (i % 2 == 0) ? 4'hA : 4'h5;
        checks++; if (g[i] !== i[0]) begin failures++; $display("FAIL contention_grant frame%0d got=%b exp=%b", i, g[i], i[0]); end
        checks++; if (wd[i] !== exp_w) begin failures++; $display("FAIL contention_word frame%0d got=%h exp=%h", i, wd[i], exp_w); end
        if (i > 0) begin
          checks++; if (st[i] - st[i-1] != 6) begin failures++; $display("FAIL contention_period frame%0d got=%0d exp=6", i, st[i] - st[i-1]); end
        end
      end
    end
    idle_inputs();
    wait_idle_a("contention");
  endtask

  task automatic test_withdraw;
    int r1_hits, en1;
    r1_hits = 0; en1 = 0;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 4'h6;
    step;
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 4'h9;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) bus_a.req1_valid = 1'b0;
      #1;
      if (bus_a.req1_ready === 1'b1) r1_hits++;
      if (bus_a.s_en === 1'b1 && bus_a.grant_id === 1'b1) en1++;
      step;
    end
    checks++; if (r1_hits != 0) begin failures++; $display("FAIL withdraw_ready1 got=%0d exp=0", r1_hits); end
    checks++; if (en1 != 0) begin failures++; $display("FAIL withdraw_req1_bits got=%0d exp=0", en1); end
  endtask

  task automatic test_data_stability;
    logic [3:0] w;
    w = '0;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 4'h3;
    #1;
    checks++; if (bus_a.req0_ready !== 1'b1) begin failures++; $display("FAIL stable_ready got=%b exp=1", bus_a.req0_ready); end
    step;
    bus_a.req0_valid = 1'b0;
    bus_a.req0_data  = 4'hC;
    for (int i = 0; i < 4; i++) begin
      #1;
      w[i] = bus_a.s_out;
      step;
    end
    checks++; if (w !== 4'h3) begin failures++; $display("FAIL stable_word got=%h exp=3", w); end
    wait_idle_a("stable");
  endtask

  task automatic test_reset_mid_frame;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 4'hF;
    step;
    bus_a.req0_valid = 1'b0;
    step;
    checks++; if ({bus_a.s_en, bus_a.s_out} !== 2'b11) begin failures++; $display("FAIL midrst_bit1 en_out got=%b exp=11", {bus_a.s_en, bus_a.s_out}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus_a.s_en, bus_a.s_out, bus_a.s_last, bus_a.busy} !== 4'b0000) begin failures++; $display("FAIL midrst_outputs got=%b exp=0000", {bus_a.s_en, bus_a.s_out, bus_a.s_last, bus_a.busy}); end
    step;
    rst_n = 1'b1;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 4'hA;
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 4'h5;
    #1;
    checks++; if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b10) begin failures++; $display("FAIL midrst_ready got=%b exp=10", {bus_a.req0_ready, bus_a.req1_ready}); end
    step;
    checks++; if ({bus_a.grant_id, bus_a.s_en, bus_a.busy} !== 3'b011) begin failures++; $display("FAIL midrst_first_grant grant_en_busy got=%b exp=011", {bus_a.grant_id, bus_a.s_en, bus_a.busy}); end
    idle_inputs();
    wait_idle_a("midrst");
  endtask

  task automatic test_gap0;
    int lc[4];
    logic g[4];
    int nl, idle_cnt;
    nl = 0; idle_cnt = 0;
    bus_b.req0_valid = 1'b1; bus_b.req0_data = 4'hA;
    bus_b.req1_valid = 1'b1; bus_b.req1_data = 4'h5;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (nl >= 1 && nl < 4 && bus_b.busy === 1'b0) idle_cnt++;
      if (bus_b.s_last === 1'b1) begin
        if (nl < 4) begin lc[nl] = c; g[nl] = bus_b.grant_id; end
        nl++;
      end
      step;
    end
    checks++;
    if (nl < 4) begin
      failures++;
      $display("FAIL gap0_frames got=%0d exp>=4", nl);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (g[i] !== i[0]) begin failures++; $display("FAIL gap0_grant frame%0d got=%b exp=%b", i, g[i], i[0]); end
        if (i > 0) begin
          checks++; if (lc[i] - lc[i-1] != 5) begin failures++; $display("FAIL gap0_period frame%0d got=%0d exp=5", i, lc[i] - lc[i-1]); end
        end
      end
      checks++; if (idle_cnt != 3) begin failures++; $display("FAIL gap0_idle_cycles got=%0d exp=3", idle_cnt); end
    end
    idle_inputs();
    for (int c = 0; c < 10; c++) step;
    checks++; if (bus_b.busy !== 1'b0) begin failures++; $display("FAIL gap0_idle_end busy=%b exp=0", bus_b.busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_withdraw();
    test_data_stability();
    test_reset_mid_frame();
    test_gap0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
